// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: states, memory commands,
// register/operand selects and the decoded instruction class.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        STATE_RESET     = 3'b000,
        STATE_HALT      = 3'b001,
        STATE_IF        = 3'b010,
        STATE_DECODE    = 3'b011,
        STATE_EXEC      = 3'b100,
        STATE_MEM       = 3'b101,
        STATE_WRITEBACK = 3'b110
    } state_t;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    localparam logic [1:0] VSEL_C      = 2'b00;
    localparam logic [1:0] VSEL_MDATA  = 2'b01;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b10;
    localparam logic [1:0] VSEL_PC     = 2'b11;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_DOUT = 2'b10;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_HALT,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ALU,
        CLS_CMP,
        CLS_LDR,
        CLS_STR,
        CLS_B,
        CLS_BL,
        CLS_BX,
        CLS_BLX
    } instr_cls_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction classifier and branch-condition evaluator.
// Branch encodings are recognised only when CTRL_BRANCH_EN is defined.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output instr_cls_t cls,
    output logic       br_taken
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            3'b111: cls = CLS_HALT;
            3'b110: begin
                if (op == 2'b10)      cls = CLS_MOV_IMM;
                else if (op == 2'b00) cls = CLS_MOV_REG;
            end
            3'b101: cls = (op == 2'b01) ? CLS_CMP : CLS_ALU;
            3'b011: if (op == 2'b00) cls = CLS_LDR;
            3'b100: if (op == 2'b00) cls = CLS_STR;
`ifdef CTRL_BRANCH_EN
            3'b001: if (op == 2'b00) cls = CLS_B;
            3'b010: begin
                case (op)
                    2'b11:   cls = CLS_BL;
                    2'b00:   cls = CLS_BX;
                    2'b10:   cls = CLS_BLX;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
`endif
            default: cls = CLS_ILLEGAL;
        endcase
    end

    // Undefined condition codes never branch.
    always_comb begin
        case (cond)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = Z;
            3'b010:  br_taken = ~Z;
            3'b011:  br_taken = N ^ V;
            3'b100:  br_taken = (N ^ V) | Z;
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle fetch/decode/execute controller for the 16-bit RISC CPU.
// Define CTRL_BRANCH_EN to accept B/BL/BX/BLX; otherwise they halt as illegal.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic [2:0] state,
    output logic [1:0] mem_cmd,
    output logic       addr_sel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic [1:0] pc_sel,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       halted
);

    localparam logic [1:0] IF_LAST  = 2'(MEM_LAT);
    localparam logic [1:0] LDR_LAST = 2'(MEM_LAT + 1);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    instr_cls_t cls;
    logic       br_taken;
    logic [1:0] bx_ph;

    cpu_ctrl_decode u_decode (
        .opcode   (opcode),
        .op       (op),
        .cond     (cond),
        .N        (N),
        .V        (V),
        .Z        (Z),
        .cls      (cls),
        .br_taken (br_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_RESET;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // BLX prepends the link write, so its BX steps run one phase late.
    assign bx_ph = (cls == CLS_BLX) ? phase_q - 2'd1 : phase_q;
    assign state = state_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 2'd1;
        mem_cmd   = MNONE;
        addr_sel  = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        pc_sel    = PC_INC;
        nsel      = 3'b000;
        vsel      = VSEL_C;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        halted    = 1'b0;

        case (state_q)
            STATE_RESET: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = STATE_IF;
            end
            STATE_IF: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
                if (phase_q == IF_LAST) begin
                    load_ir = 1'b1;
                    state_d = STATE_DECODE;
                end
            end
            STATE_DECODE: begin
                load_pc = 1'b1;
                pc_sel  = PC_INC;
                case (cls)
                    CLS_MOV_IMM: state_d = STATE_WRITEBACK;
                    CLS_MOV_REG, CLS_ALU, CLS_CMP, CLS_LDR, CLS_STR,
                    CLS_B, CLS_BL, CLS_BX, CLS_BLX: state_d = STATE_EXEC;
                    default: state_d = STATE_HALT;
                endcase
            end
            STATE_EXEC: begin
                case (cls)
                    CLS_B: begin
                        if (br_taken) begin
                            load_pc = 1'b1;
                            pc_sel  = PC_BR;
                        end
                        state_d = STATE_IF;
                    end
                    CLS_BL: begin
                        if (phase_q == 2'd0) begin
                            write = 1'b1;
                            nsel  = NSEL_RN;
                            vsel  = VSEL_PC;
                        end else begin
                            load_pc = 1'b1;
                            pc_sel  = PC_BR;
                            state_d = STATE_IF;
                        end
                    end
                    CLS_BX, CLS_BLX: begin
                        if (cls == CLS_BLX && phase_q == 2'd0) begin
                            write = 1'b1;
                            nsel  = NSEL_RN;
                            vsel  = VSEL_PC;
                        end else if (bx_ph == 2'd0) begin
                            nsel  = NSEL_RD;
                            loadb = 1'b1;
                        end else if (bx_ph == 2'd1) begin
                            asel  = 1'b1;
                            loadc = 1'b1;
                        end else begin
                            load_pc = 1'b1;
                            pc_sel  = PC_DOUT;
                            state_d = STATE_IF;
                        end
                    end
                    default: begin
                        if (phase_q == 2'd0) begin
                            if (cls != CLS_MOV_REG) begin
                                nsel  = NSEL_RN;
                                loada = 1'b1;
                            end
                        end else if (phase_q == 2'd1) begin
                            if (cls != CLS_LDR) begin
                                nsel  = (cls == CLS_STR) ? NSEL_RD : NSEL_RM;
                                loadb = 1'b1;
                            end
                        end else begin
                            asel  = (cls == CLS_MOV_REG);
                            bsel  = (cls == CLS_LDR) || (cls == CLS_STR);
                            loads = (cls == CLS_CMP);
                            loadc = (cls != CLS_CMP);
                            if (cls == CLS_CMP)
                                state_d = STATE_IF;
                            else if (cls == CLS_LDR || cls == CLS_STR)
                                state_d = STATE_MEM;
                            else
                                state_d = STATE_WRITEBACK;
                        end
                    end
                endcase
            end
            STATE_MEM: begin
                if (phase_q == 2'd0) begin
                    load_addr = 1'b1;
                end else if (cls == CLS_STR) begin
                    if (phase_q == 2'd1) begin
                        asel  = 1'b1;
                        loadc = 1'b1;
                    end else begin
                        addr_sel = 1'b0;
                        mem_cmd  = MWRITE;
                        state_d  = STATE_IF;
                    end
                end else begin
                    addr_sel = 1'b0;
                    mem_cmd  = MREAD;
                    if (phase_q == LDR_LAST)
                        state_d = STATE_WRITEBACK;
                end
            end
            STATE_WRITEBACK: begin
                write = 1'b1;
                nsel  = NSEL_RD;
                if (cls == CLS_MOV_IMM)
                    vsel = VSEL_SXIMM8;
                else if (cls == CLS_LDR)
                    vsel = VSEL_MDATA;
                else
                    vsel = VSEL_C;
                state_d = STATE_IF;
            end
            STATE_HALT: begin
                halted  = 1'b1;
                phase_d = phase_q;
            end
            default: state_d = STATE_RESET;
        endcase

        if (state_d != state_q)
            phase_d = 2'd0;
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed scoreboard bench for cpu_ctrl_fsm: per-cycle expected control
// vectors are queued per instruction and compared against the DUT each cycle.
module tb_cpu_ctrl_fsm;

    localparam int LAT = 1;

    localparam logic [2:0] S_RESET = 3'b000, S_HALT = 3'b001, S_IF = 3'b010,
                           S_DEC = 3'b011, S_EXEC = 3'b100, S_MEM = 3'b101, S_WB = 3'b110;
    localparam logic [1:0] C_READ = 2'b01, C_WRITE = 2'b10;
    localparam logic [1:0] V_C = 2'b00, V_MDATA = 2'b01, V_SXIMM8 = 2'b10;
    localparam logic [2:0] RN = cpu_ctrl_pkg::NSEL_RN;
    localparam logic [2:0] RD = cpu_ctrl_pkg::NSEL_RD;
    localparam logic [2:0] RM = cpu_ctrl_pkg::NSEL_RM;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] mem_cmd;
        logic       addr_sel, load_ir, load_pc, reset_pc, load_addr;
        logic [1:0] pc_sel;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write, loada, loadb, loadc, loads, asel, bsel, halted;
    } ctl_t;

    logic       clk, reset, N, V, Z;
    logic [2:0] opcode, cond, state, nsel;
    logic [1:0] op, mem_cmd, pc_sel, vsel;
    logic       addr_sel, load_ir, load_pc, reset_pc, load_addr;
    logic       write, loada, loadb, loadc, loads, asel, bsel, halted;

    ctl_t obs;
    ctl_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    cpu_ctrl_fsm #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .N(N), .V(V), .Z(Z), .state(state), .mem_cmd(mem_cmd),
        .addr_sel(addr_sel), .load_ir(load_ir), .load_pc(load_pc),
        .reset_pc(reset_pc), .load_addr(load_addr), .pc_sel(pc_sel),
        .nsel(nsel), .vsel(vsel), .write(write), .loada(loada),
        .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
        .bsel(bsel), .halted(halted)
    );

    assign obs = {state, mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr,
                  pc_sel, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ctl_t mk(input logic [2:0] s);
        ctl_t e;
        e = '0;
        e.state = s;
        return e;
    endfunction

    task automatic check_one();
        ctl_t e;
        e = exp_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL cyc%0d state%0d: observed %h expected %h", cyc, e.state, obs, e);
        end
    endtask

    task automatic push_if_dec();
        ctl_t e;
        for (int p = 0; p <= LAT; p++) begin
            e = mk(S_IF); e.addr_sel = 1'b1; e.mem_cmd = C_READ; e.load_ir = (p == LAT);
            exp_q.push_back(e);
        end
        e = mk(S_DEC); e.load_pc = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_exec(input logic skip_a, input logic do_b, input logic [2:0] bn,
                             input logic as, input logic bs, input logic cmp);
        ctl_t e;
        e = mk(S_EXEC);
        if (!skip_a) begin e.nsel = RN; e.loada = 1'b1; end
        exp_q.push_back(e);
        e = mk(S_EXEC);
        if (do_b) begin e.nsel = bn; e.loadb = 1'b1; end
        exp_q.push_back(e);
        e = mk(S_EXEC); e.asel = as; e.bsel = bs;
        if (cmp) e.loads = 1'b1; else e.loadc = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_wb(input logic [1:0] vs);
        ctl_t e;
        e = mk(S_WB); e.write = 1'b1; e.nsel = RD; e.vsel = vs;
        exp_q.push_back(e);
    endtask

    task automatic push_halt(input int n);
        ctl_t e;
        for (int i = 0; i < n; i++) begin
            e = mk(S_HALT); e.halted = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_str_mem(input logic full);
        ctl_t e;
        e = mk(S_MEM); e.load_addr = 1'b1; exp_q.push_back(e);
        e = mk(S_MEM); e.asel = 1'b1; e.loadc = 1'b1; exp_q.push_back(e);
        if (full) begin
            e = mk(S_MEM); e.mem_cmd = C_WRITE; exp_q.push_back(e);
        end
    endtask

    task automatic push_ldr_mem();
        ctl_t e;
        e = mk(S_MEM); e.load_addr = 1'b1; exp_q.push_back(e);
        for (int p = 1; p <= LAT + 1; p++) begin
            e = mk(S_MEM); e.mem_cmd = C_READ; exp_q.push_back(e);
        end
    endtask

    // Instruction fields are applied in the first IF cycle, after the
    // previous instruction's final transition has been taken.
    task automatic run(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                       input logic n, input logic v, input logic z);
        @(posedge clk); #1;
        opcode = opc; op = o; cond = c; N = n; V = v; Z = z;
        check_one();
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            check_one();
        end
    endtask

    task automatic reset_pulse();
        ctl_t e;
        reset = 1'b1;
        e = mk(S_RESET); e.reset_pc = 1'b1; e.load_pc = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        check_one();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; opcode = 3'b000; op = 2'b00; cond = 3'b000;
        N = 1'b0; V = 1'b0; Z = 1'b0;
        reset_pulse();

        push_if_dec(); push_wb(V_SXIMM8);                                   // MOV R0,#7
        run(3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b0, 1'b1, RM, 1'b0, 1'b0, 1'b0); push_wb(V_C); // ADD
        run(3'b101, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b1, 1'b1, RM, 1'b1, 1'b0, 1'b0); push_wb(V_C); // MOV reg
        run(3'b110, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b0, 1'b1, RD, 1'b0, 1'b1, 1'b0); push_str_mem(1'b1); // STR
        run(3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); push_ldr_mem(); push_wb(V_MDATA); // LDR
        run(3'b011, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b0, 1'b1, RM, 1'b0, 1'b0, 1'b1);        // CMP
        run(3'b101, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b0, 1'b1, RM, 1'b0, 1'b0, 1'b0); push_wb(V_C); // MVN
        run(3'b101, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0);

        push_if_dec(); push_exec(1'b0, 1'b1, RD, 1'b0, 1'b1, 1'b0); push_str_mem(1'b0); // STR cut by reset
        run(3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        reset_pulse();

`ifdef CTRL_BRANCH_EN
        begin
            ctl_t e;
            push_if_dec();
            e = mk(S_EXEC); e.load_pc = 1'b1; e.pc_sel = 2'b01; exp_q.push_back(e);
            run(3'b001, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1);                   // BEQ taken
            push_if_dec();
            e = mk(S_EXEC); exp_q.push_back(e);
            run(3'b001, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0);                   // BEQ not taken
        end
        push_if_dec(); push_halt(3);                                         // illegal MOV op
        run(3'b110, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
        reset_pulse();
`else
        push_if_dec(); push_halt(3);                                         // B is illegal here
        run(3'b001, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
        reset_pulse();
`endif

        push_if_dec(); push_halt(20);                                        // HALT
        run(3'b111, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        reset_pulse();

        push_if_dec(); push_wb(V_SXIMM8);
        run(3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
